// File: rtl/pipe_sched.sv
// pipe_sched: central pipeline sequencer for the 5-stage CPU.
// One FSM (RUN / MDU_WAIT / HALT / RESUME) drives the PC and stage-register
// enables and bubble controls. Decoded outputs are combinational from state
// and inputs; all state is registered.
// Optional macro PIPE_SCHED_PERF_CNT_EN adds cycle/stall/flush counters;
// without it the counter outputs are tied to 0.
module pipe_sched #(
  parameter int CNT_W   = 32,
  parameter int MDU_MAX = 64
) (
  input  logic             clk,
  input  logic             CLR,
  input  logic             halt_req,
  input  logic             GO,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             mdu_start,
  input  logic             mdu_done,
  output logic             pc_en,
  output logic             en1,
  output logic             en2,
  output logic             en3,
  output logic             en4,
  output logic             flush1,
  output logic             flush2,
  output logic             flush3,
  output logic             halted,
  output logic             mdu_err,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int TW = $clog2(MDU_MAX) + 1;

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_MDU    = 2'd1,
    S_HALT   = 2'd2,
    S_RESUME = 2'd3
  } state_t;

  state_t          r_state;
  logic            r_mdu_pend;
  logic            r_mdu_err;
  logic            r_go_q;
  logic [TW-1:0]   r_tmo;

  logic            w_go_rise;
  logic [4:0]      w_en;   // {pc_en, en1, en2, en3, en4}
  logic [2:0]      w_fl;   // {flush1, flush2, flush3}

  assign w_go_rise = GO & ~r_go_q;

  // Decode enables/bubbles from current state and hazard inputs
  always_comb begin
    w_en = 5'b00000;
    w_fl = 3'b000;
    if (!CLR) begin
      case (r_state)
        S_RUN: begin
          if (halt_req) begin
            w_en = 5'b00000;
          end else if (mdu_start) begin
            w_en = 5'b11111;
          end else if (branch_taken) begin
            // Redirect wins over load-use so the PC takes the target
            w_en = 5'b11111;
            w_fl = 3'b110;
          end else if (load_use) begin
            w_en = 5'b00111;
            w_fl = 3'b010;
          end else begin
            w_en = 5'b11111;
          end
        end
        S_MDU: begin
          // EX holds the MUL/DIV op; older instructions drain behind a bubble
          w_en = 5'b00011;
          w_fl = 3'b001;
        end
        S_HALT:   w_en = 5'b00000;
        S_RESUME: w_en = 5'b11111;
        default:  w_en = 5'b00000;
      endcase
    end
  end

  assign pc_en   = w_en[4];
  assign en1     = w_en[3];
  assign en2     = w_en[2];
  assign en3     = w_en[1];
  assign en4     = w_en[0];
  assign flush1  = w_fl[2];
  assign flush2  = w_fl[1];
  assign flush3  = w_fl[0];
  assign halted  = (r_state == S_HALT);
  assign mdu_err = r_mdu_err;

  // Sequencer FSM: state, MDU pending/timeout tracking, GO edge history
  always_ff @(posedge clk) begin
    if (CLR) begin
      r_state    <= S_RUN;
      r_mdu_pend <= 1'b0;
      r_mdu_err  <= 1'b0;
      r_go_q     <= 1'b0;
      r_tmo      <= '0;
    end else begin
      r_go_q <= GO;
      // A done pulse in any state retires the pending op; a start in the
      // same cycle (RUN arm below) takes precedence.
      if (mdu_done) r_mdu_pend <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (halt_req) begin
            r_state <= S_HALT;
          end else if (mdu_start) begin
            r_mdu_pend <= 1'b1;
            r_tmo      <= '0;
            r_state    <= S_MDU;
          end
        end
        S_MDU: begin
          if (halt_req) begin
            r_state <= S_HALT;
          end else if (mdu_done) begin
            r_state <= S_RUN;
          end else if (r_tmo == TW'(MDU_MAX - 1)) begin
            r_mdu_err  <= 1'b1;
            r_mdu_pend <= 1'b0;
            r_state    <= S_RUN;
          end else begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_HALT: begin
          if (w_go_rise) r_state <= S_RESUME;
        end
        S_RESUME: begin
          // Timeout count continues where it left off if we return to wait
          r_state <= r_mdu_pend ? S_MDU : S_RUN;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

`ifdef PIPE_SCHED_PERF_CNT_EN
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Performance counters, free-running modulo 2^CNT_W
  always_ff @(posedge clk) begin
    if (CLR) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (r_state != S_HALT)           r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
      if (!pc_en && r_state != S_HALT) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (flush1)                      r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`else
  assign cycle_cnt = '0;
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: directed stimulus for pipe_sched with a behavioural model
// checked every cycle, plus literal expectations at key points.
module tb_pipe_sched;

  localparam int CNT_W   = 32;
  localparam int MDU_MAX = 8;

  logic clk = 1'b0;
  logic CLR = 1'b1;
  logic halt_req = 1'b0, GO = 1'b0, load_use = 1'b0, branch_taken = 1'b0;
  logic mdu_start = 1'b0, mdu_done = 1'b0;
  logic pc_en, en1, en2, en3, en4, flush1, flush2, flush3, halted, mdu_err;
  logic [CNT_W-1:0] cycle_cnt, stall_cnt, flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_sched #(.CNT_W(CNT_W), .MDU_MAX(MDU_MAX)) dut (
    .clk(clk), .CLR(CLR), .halt_req(halt_req), .GO(GO), .load_use(load_use),
    .branch_taken(branch_taken), .mdu_start(mdu_start), .mdu_done(mdu_done),
    .pc_en(pc_en), .en1(en1), .en2(en2), .en3(en3), .en4(en4),
    .flush1(flush1), .flush2(flush2), .flush3(flush3), .halted(halted),
    .mdu_err(mdu_err), .cycle_cnt(cycle_cnt), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Mode of the sequencer as the spec describes it, tracked with plain ints.
  localparam int M_RUN = 0, M_WAIT = 1, M_HALT = 2, M_RES = 3;
  int  m_mode = M_RUN;
  bit  m_pend = 0, m_err = 0, m_goq = 0, m_on = 0;
  int  m_waited = 0;
  longint unsigned m_cyc = 0, m_stl = 0, m_fls = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (CLR) begin
        chk("clr_en", {27'd0, pc_en, en1, en2, en3, en4}, 32'd0);
        chk("clr_fl", {29'd0, flush1, flush2, flush3}, 32'd0);
        m_mode = M_RUN; m_pend = 0; m_err = 0; m_goq = 0; m_waited = 0;
        m_cyc = 0; m_stl = 0; m_fls = 0; m_on = 1;
      end else if (m_on) begin
        logic [4:0] e_en;
        logic [2:0] e_fl;
        int nmode;
        nmode = m_mode;
        e_fl  = 3'b000;
        e_en  = 5'b11111;
        if (m_mode == M_RUN) begin
          if (halt_req) begin e_en = 5'b00000; nmode = M_HALT; end
          else if (mdu_start) nmode = M_WAIT;
          else if (branch_taken) e_fl = 3'b110;
          else if (load_use) begin e_en = 5'b00111; e_fl = 3'b010; end
        end else if (m_mode == M_WAIT) begin
          e_en = 5'b00011; e_fl = 3'b001;
          if (halt_req) nmode = M_HALT;
          else if (mdu_done) nmode = M_RUN;
          else if (m_waited + 1 >= MDU_MAX) nmode = M_RUN;  // this is the last allowed wait cycle
        end else if (m_mode == M_HALT) begin
          e_en = 5'b00000;
          if (GO && !m_goq) nmode = M_RES;
        end else begin
          nmode = m_pend ? M_WAIT : M_RUN;
        end
        chk("en", {27'd0, pc_en, en1, en2, en3, en4}, {27'd0, e_en});
        chk("flush", {29'd0, flush1, flush2, flush3}, {29'd0, e_fl});
        chk("halted", {31'd0, halted}, {31'd0, m_mode == M_HALT});
        chk("mdu_err", {31'd0, mdu_err}, {31'd0, m_err});
`ifdef PIPE_SCHED_PERF_CNT_EN
        chk("cycle_cnt", cycle_cnt, m_cyc[31:0]);
        chk("stall_cnt", stall_cnt, m_stl[31:0]);
        chk("flush_cnt", flush_cnt, m_fls[31:0]);
`else
        chk("cycle_cnt", cycle_cnt, 32'd0);
        chk("stall_cnt", stall_cnt, 32'd0);
        chk("flush_cnt", flush_cnt, 32'd0);
`endif
        // advance model to the next cycle
        if (m_mode != M_HALT) m_cyc++;
        if (!e_en[4] && m_mode != M_HALT) m_stl++;
        if (e_fl[2]) m_fls++;
        if (m_mode == M_RUN && !halt_req && mdu_start) begin
          m_pend = 1; m_waited = 0;
        end else if (mdu_done) m_pend = 0;
        if (m_mode == M_WAIT && !halt_req && !mdu_done) begin
          if (m_waited + 1 >= MDU_MAX) begin m_err = 1; m_pend = 0; end
          else m_waited++;
        end
        m_goq  = GO;
        m_mode = nmode;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  // Apply one cycle of inputs just after the edge; return at the negedge.
  task automatic step(input bit c, input bit hr, input bit g, input bit lu,
                      input bit bt, input bit ms, input bit md);
    @(posedge clk); #1;
    CLR = c; halt_req = hr; GO = g; load_use = lu;
    branch_taken = bt; mdu_start = ms; mdu_done = md;
    @(negedge clk); #1;
  endtask

  task automatic lit(input string nm, input logic [4:0] e, input logic [2:0] f);
    chk({nm, "_en"}, {27'd0, pc_en, en1, en2, en3, en4}, {27'd0, e});
    chk({nm, "_fl"}, {29'd0, flush1, flush2, flush3}, {29'd0, f});
  endtask

  task automatic lit_cnt(input string nm, input logic [31:0] got, input logic [31:0] e);
`ifdef PIPE_SCHED_PERF_CNT_EN
    chk(nm, got, e);
`else
    chk(nm, got, 32'd0);
`endif
  endtask

  initial begin
    // reset, then idle
    step(1,0,0,0,0,0,0);
    step(1,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0);
    lit("reset_idle", 5'b11111, 3'b000);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    lit_cnt("cyc0", cycle_cnt, 32'd0);
    lit_cnt("stl0", stall_cnt, 32'd0);
    step(0,0,0,0,0,0,0); lit_cnt("cyc1", cycle_cnt, 32'd1);
    step(0,0,0,0,0,0,0); lit_cnt("cyc2", cycle_cnt, 32'd2);

    // load-use stall, then branch overriding load-use
    step(0,0,0,1,0,0,0); lit("load_use", 5'b00111, 3'b010);
    step(0,0,0,1,1,0,0); lit("br_over_lu", 5'b11111, 3'b110);
    lit_cnt("stl1", stall_cnt, 32'd1);
    step(0,0,0,0,0,0,0); lit_cnt("fls1", flush_cnt, 32'd1);

    // halt with GO already high: no resume until a fresh rising edge
    step(0,0,1,0,0,0,0);
    step(0,1,1,0,0,0,0); lit("halt_req_run", 5'b00000, 3'b000);
    for (int i = 0; i < 4; i++) begin
      step(0,1,1,0,0,0,0);
      chk("halt_hold", {31'd0, halted}, 32'd1);
    end
    lit("halt_en", 5'b00000, 3'b000);
    step(0,1,0,0,0,0,0); chk("halt_go0", {31'd0, halted}, 32'd1);
    step(0,1,1,0,0,0,0); chk("halt_gorise", {31'd0, halted}, 32'd1);
    step(0,1,1,0,0,0,0); lit("resume", 5'b11111, 3'b000);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    step(0,0,1,0,0,0,0); lit("after_resume", 5'b11111, 3'b000);

    // MDU op finishing on its fifth wait cycle
    step(0,0,0,0,0,1,0); lit("mdu_start", 5'b11111, 3'b000);
    for (int i = 0; i < 4; i++) begin
      step(0,0,0,0,0,0,0); lit("mdu_wait", 5'b00011, 3'b001);
    end
    step(0,0,0,0,0,0,1); lit("mdu_wait5", 5'b00011, 3'b001);
    step(0,0,0,0,0,0,0); lit("mdu_back", 5'b11111, 3'b000);
    chk("mdu_err0", {31'd0, mdu_err}, 32'd0);

    // MDU timeout: MDU_MAX wait cycles then forced exit with sticky error
    step(0,0,0,0,0,1,0);
    for (int i = 0; i < MDU_MAX; i++) begin
      step(0,0,0,0,0,0,0); lit("tmo_wait", 5'b00011, 3'b001);
    end
    step(0,0,0,0,0,0,0); lit("tmo_exit", 5'b11111, 3'b000);
    chk("tmo_err", {31'd0, mdu_err}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(0,0,0,0,0,0,0); chk("err_sticky", {31'd0, mdu_err}, 32'd1);
    end
    step(1,0,0,0,0,0,0);
    step(0,0,0,0,0,0,0); chk("err_clr", {31'd0, mdu_err}, 32'd0);
    lit_cnt("cyc_clr", cycle_cnt, 32'd0);

    // halt during MDU wait, done arrives while halted -> resume to RUN
    step(0,0,0,0,0,1,0);
    step(0,0,0,0,0,0,0); lit("mh_wait", 5'b00011, 3'b001);
    step(0,1,0,0,0,0,0); lit("mh_wait_hr", 5'b00011, 3'b001);
    step(0,1,0,0,0,0,0); chk("mh_halted", {31'd0, halted}, 32'd1);
    step(0,0,0,0,0,0,1); chk("mh_done", {31'd0, halted}, 32'd1);
    step(0,0,0,0,0,0,0);
    step(0,0,1,0,0,0,0); chk("mh_gorise", {31'd0, halted}, 32'd1);
    step(0,0,1,0,0,0,0); lit("mh_resume", 5'b11111, 3'b000);
    step(0,0,1,0,0,0,0); lit("mh_run", 5'b11111, 3'b000);
    step(0,0,0,0,0,0,0); lit("mh_run2", 5'b11111, 3'b000);

    // back-to-back SYSCALL: halt_req still high after RESUME halts again
    step(0,1,0,0,0,0,0);
    step(0,1,0,0,0,0,0);
    step(0,1,1,0,0,0,0);
    step(0,1,1,0,0,0,0); lit("b2b_resume", 5'b11111, 3'b000);
    step(0,1,1,0,0,0,0); lit("b2b_rehalt", 5'b00000, 3'b000);
    step(0,1,1,0,0,0,0); chk("b2b_halted", {31'd0, halted}, 32'd1);

    step(0,0,0,0,0,0,0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
